// File: rtl/ball_renderer.sv
// rtl/ball_renderer.sv - raster sync/video/pixel generator with a bouncing square ball
module ball_renderer #(
    parameter int H_VISIBLE    = 640,
    parameter int V_VISIBLE    = 480,
    parameter int H_SYNC_START = 657,
    parameter int H_SYNC_END   = 752,
    parameter int V_SYNC_START = 491,
    parameter int V_SYNC_END   = 492,
    parameter int H_MAX        = 800,
    parameter int V_MAX        = 525,
    parameter int BALL_SIZE    = 8,
    parameter int SPEED        = 2,
    parameter int X_INIT       = 100,
    parameter int Y_INIT       = 100
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic [9:0] i_HPos,
    input  logic [9:0] i_VPos,
    input  logic       i_Enable,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic       o_Video,
    output logic       o_Pixel,
    output logic [9:0] o_BallX,
    output logic [9:0] o_BallY,
    output logic [7:0] o_Bounces
);

    // All position arithmetic is done in 11 bits so sums never wrap.
    localparam logic [10:0] XMAX11   = 11'(H_VISIBLE - BALL_SIZE + 1);
    localparam logic [10:0] YMAX11   = 11'(V_VISIBLE - BALL_SIZE + 1);
    localparam logic [10:0] SPEED11  = 11'(SPEED);
    localparam logic [10:0] BALL11   = 11'(BALL_SIZE);
    localparam logic [10:0] HVIS11   = 11'(H_VISIBLE);
    localparam logic [10:0] VVIS11   = 11'(V_VISIBLE);
    localparam logic [10:0] HSS11    = 11'(H_SYNC_START);
    localparam logic [10:0] HSE11    = 11'(H_SYNC_END);
    localparam logic [10:0] VSS11    = 11'(V_SYNC_START);
    localparam logic [10:0] VSE11    = 11'(V_SYNC_END);
    localparam logic [10:0] HMAX11   = 11'(H_MAX);
    localparam logic [10:0] VMAX11   = 11'(V_MAX);
    localparam logic [9:0]  XINIT10  = 10'(X_INIT);
    localparam logic [9:0]  YINIT10  = 10'(Y_INIT);

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        RUN        = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        video_q, video_d;
    logic        pixel_q, pixel_d;
    logic [9:0]  ball_x_q, ball_x_d;
    logic [9:0]  ball_y_q, ball_y_d;
    logic        dir_right_q, dir_right_d;
    logic        dir_down_q, dir_down_d;
    logic [7:0]  bounces_q, bounces_d;
    logic        bounce_x, bounce_y;

    logic [10:0] hpos11, vpos11, bx11, by11;
    logic        fup;

    assign hpos11 = {1'b0, i_HPos};
    assign vpos11 = {1'b0, i_VPos};
    assign bx11   = {1'b0, ball_x_q};
    assign by11   = {1'b0, ball_y_q};
    assign fup    = (hpos11 == HMAX11) && (vpos11 == VMAX11);

    // Raster decode for the current position; registered below for 1-cycle latency.
    always_comb begin
        hsync_d = !((hpos11 >= HSS11) && (hpos11 <= HSE11));
        vsync_d = !((vpos11 >= VSS11) && (vpos11 <= VSE11));
        video_d = (hpos11 <= HVIS11) && (vpos11 <= VVIS11);
        pixel_d = video_d
                  && (hpos11 >= bx11) && (hpos11 <= bx11 + BALL11 - 11'd1)
                  && (vpos11 >= by11) && (vpos11 <= by11 + BALL11 - 11'd1);
    end

    // Raster output registers.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            video_q <= 1'b0;
            pixel_q <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
            pixel_q <= pixel_d;
        end
    end

    // Motion FSM: the first frame-update point only arms motion, later ones move the ball.
    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        dir_right_d = dir_right_q;
        dir_down_d  = dir_down_q;
        bounce_x    = 1'b0;
        bounce_y    = 1'b0;
        if (fup) begin
            case (state_q)
                WAIT_FRAME: state_d = RUN;
                RUN: begin
                    if (i_Enable) begin
                        if (dir_right_q) begin
                            if (bx11 + SPEED11 >= XMAX11) begin
                                ball_x_d    = XMAX11[9:0];
                                dir_right_d = 1'b0;
                                bounce_x    = 1'b1;
                            end else begin
                                ball_x_d = 10'(bx11 + SPEED11);
                            end
                        end else begin
                            if (bx11 <= SPEED11 + 11'd1) begin
                                ball_x_d    = 10'd1;
                                dir_right_d = 1'b1;
                                bounce_x    = 1'b1;
                            end else begin
                                ball_x_d = 10'(bx11 - SPEED11);
                            end
                        end
                        if (dir_down_q) begin
                            if (by11 + SPEED11 >= YMAX11) begin
                                ball_y_d   = YMAX11[9:0];
                                dir_down_d = 1'b0;
                                bounce_y   = 1'b1;
                            end else begin
                                ball_y_d = 10'(by11 + SPEED11);
                            end
                        end else begin
                            if (by11 <= SPEED11 + 11'd1) begin
                                ball_y_d   = 10'd1;
                                dir_down_d = 1'b1;
                                bounce_y   = 1'b1;
                            end else begin
                                ball_y_d = 10'(by11 - SPEED11);
                            end
                        end
                    end
                end
                default: state_d = WAIT_FRAME;
            endcase
        end
        bounces_d = bounces_q + {7'd0, bounce_x} + {7'd0, bounce_y};
    end

    // Ball state registers; they only change at a frame-update point.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= WAIT_FRAME;
            ball_x_q    <= XINIT10;
            ball_y_q    <= YINIT10;
            dir_right_q <= 1'b1;
            dir_down_q  <= 1'b1;
            bounces_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            dir_right_q <= dir_right_d;
            dir_down_q  <= dir_down_d;
            bounces_q   <= bounces_d;
        end
    end

    assign o_HSync   = hsync_q;
    assign o_VSync   = vsync_q;
    assign o_Video   = video_q;
    assign o_Pixel   = pixel_q;
    assign o_BallX   = ball_x_q;
    assign o_BallY   = ball_y_q;
    assign o_Bounces = bounces_q;

endmodule

// File: tb/tb_ball_renderer.sv
// tb/tb_ball_renderer.sv - self-checking bench for ball_renderer
module tb_ball_renderer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] hpos = 10'd1;
    logic [9:0] vpos = 10'd1;
    logic       en = 1'b1;
    logic       hs, vs, vid, pix;
    logic [9:0] bx, by;
    logic [7:0] bc;

    always #5 clk = ~clk;

    ball_renderer dut (
        .i_Clk     (clk),
        .i_Rst_n   (rst_n),
        .i_HPos    (hpos),
        .i_VPos    (vpos),
        .i_Enable  (en),
        .o_HSync   (hs),
        .o_VSync   (vs),
        .o_Video   (vid),
        .o_Pixel   (pix),
        .o_BallX   (bx),
        .o_BallY   (by),
        .o_Bounces (bc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: geometry from the raster rules, ball as plain integers.
    localparam int XMAX = 633;
    localparam int YMAX = 473;
    localparam int SPD  = 2;
    localparam int BS   = 8;

    int m_x = 100, m_y = 100, m_b = 0, m_nb = 0;
    bit m_right = 1'b1, m_down = 1'b1, m_run = 1'b0;
    bit e_hs = 1'b1, e_vs = 1'b1, e_vid = 1'b0, e_pix = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        int h, v;
        if (!rst_n) begin
            m_x = 100; m_y = 100; m_b = 0; m_nb = 0;
            m_right = 1'b1; m_down = 1'b1; m_run = 1'b0;
            e_hs = 1'b1; e_vs = 1'b1; e_vid = 1'b0; e_pix = 1'b0;
        end else begin
            h = int'(hpos);
            v = int'(vpos);
            e_hs  = !(h >= 657 && h <= 752);
            e_vs  = !(v >= 491 && v <= 492);
            e_vid = (h <= 640) && (v <= 480);
            e_pix = e_vid && h >= m_x && h <= m_x + BS - 1 && v >= m_y && v <= m_y + BS - 1;
            m_nb = 0;
            if (h == 800 && v == 525) begin
                if (!m_run) begin
                    m_run = 1'b1;
                end else if (en) begin
                    if (m_right) begin
                        if (m_x + SPD >= XMAX) begin m_x = XMAX; m_right = 1'b0; m_nb++; end
                        else m_x = m_x + SPD;
                    end else begin
                        if (m_x - SPD <= 1) begin m_x = 1; m_right = 1'b1; m_nb++; end
                        else m_x = m_x - SPD;
                    end
                    if (m_down) begin
                        if (m_y + SPD >= YMAX) begin m_y = YMAX; m_down = 1'b0; m_nb++; end
                        else m_y = m_y + SPD;
                    end else begin
                        if (m_y - SPD <= 1) begin m_y = 1; m_down = 1'b1; m_nb++; end
                        else m_y = m_y - SPD;
                    end
                    m_b = (m_b + m_nb) % 256;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("hsync", int'(hs), int'(e_hs));
            chk("vsync", int'(vs), int'(e_vs));
            chk("video", int'(vid), int'(e_vid));
            chk("pixel", int'(pix), int'(e_pix));
            chk("ball_x", int'(bx), m_x);
            chk("ball_y", int'(by), m_y);
            chk("bounces", int'(bc), m_b);
        end
    end

    // Apply one position for one clock; returns just after the capturing edge.
    task automatic step(input int h, input int v, input bit e);
        @(negedge clk);
        hpos = 10'(h);
        vpos = 10'(v);
        en   = e;
        @(posedge clk);
        #1;
    endtask

    int hs_low, vid_cnt, pix_cnt, pix_bad, b_before, wraps;
    bit corner_found, ybounce;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_hsync", int'(hs), 1);
        chk("reset_vsync", int'(vs), 1);
        chk("reset_video", int'(vid), 0);
        chk("reset_pixel", int'(pix), 0);
        chk("reset_x", int'(bx), 100);
        chk("reset_y", int'(by), 100);
        chk("reset_bounces", int'(bc), 0);
        chk_en = 1'b1;

        // One full line: sync and video widths
        hs_low = 0; vid_cnt = 0;
        for (int h = 1; h <= 800; h++) begin
            step(h, 1, 1'b1);
            if (!hs) hs_low++;
            if (vid) vid_cnt++;
        end
        chk("hsync_low_count", hs_low, 96);
        chk("video_count_line", vid_cnt, 640);

        step(1, 490, 1'b1); chk("vsync_490", int'(vs), 1);
        step(1, 491, 1'b1); chk("vsync_491", int'(vs), 0);
        step(1, 492, 1'b1); chk("vsync_492", int'(vs), 0);
        step(1, 493, 1'b1); chk("vsync_493", int'(vs), 1);
        step(641, 480, 1'b1); chk("video_641", int'(vid), 0);
        step(640, 481, 1'b1); chk("video_481", int'(vid), 0);
        step(640, 480, 1'b1); chk("video_corner", int'(vid), 1);
        step(0, 0, 1'b1); chk("video_zero", int'(vid), 1);

        // Ball footprint at (100,100)
        pix_cnt = 0; pix_bad = 0;
        for (int v = 98; v <= 109; v++) begin
            for (int h = 1; h <= 800; h++) begin
                step(h, v, 1'b1);
                if (pix) begin
                    pix_cnt++;
                    if (h < 100 || h > 107 || v < 100 || v > 107) pix_bad++;
                end
            end
        end
        chk("pixel_count", pix_cnt, 64);
        chk("pixel_outside", pix_bad, 0);
        step(108, 100, 1'b1); chk("pixel_h108", int'(pix), 0);
        step(107, 107, 1'b1); chk("pixel_h107", int'(pix), 1);

        // First frame-update point arms only; second moves
        step(800, 525, 1'b1);
        chk("fup1_x", int'(bx), 100);
        chk("fup1_y", int'(by), 100);
        step(800, 525, 1'b1);
        chk("fup2_x", int'(bx), 102);
        chk("fup2_y", int'(by), 102);

        // Enable low across two FUPs holds the ball
        step(800, 525, 1'b0);
        step(5, 5, 1'b0);
        step(800, 525, 1'b0);
        chk("hold_x", int'(bx), 102);
        chk("hold_y", int'(by), 102);

        // Run up to X=632 moving right
        for (int i = 0; i < 2000 && !(m_x == 632 && m_right); i++)
            step(800, 525, 1'b1);
        chk("runup_reached", int'(m_x == 632 && m_right), 1);
        b_before = m_b;
        ybounce  = (m_down && m_y + SPD >= YMAX) || (!m_down && m_y - SPD <= 1);
        step(800, 525, 1'b1);
        chk("right_bounce_x", int'(bx), 633);
        chk("right_bounce_cnt", int'(bc), (b_before + 1 + int'(ybounce)) % 256);
        step(800, 525, 1'b1);
        chk("after_bounce_x", int'(bx), 631);

        // Long run until both axes hit the top-left corner together
        corner_found = 1'b0; wraps = 0;
        for (int i = 0; i < 40000 && !corner_found; i++) begin
            if (i % 32 == 31)
                step($urandom_range(0, 799), $urandom_range(0, 1023), 1'($urandom));
            if (m_x == 3 && !m_right && m_y == 3 && !m_down) begin
                b_before = m_b;
                step(800, 525, 1'b1);
                chk("corner_x", int'(bx), 1);
                chk("corner_y", int'(by), 1);
                chk("corner_cnt", int'(bc), (b_before + 2) % 256);
                corner_found = 1'b1;
            end else begin
                b_before = m_b;
                step(800, 525, 1'b1);
                if (b_before == 255 && m_nb > 0) begin
                    chk("bounce_wrap", int'(bc), m_nb - 1);
                    wraps++;
                end
            end
        end
        chk("corner_found", int'(corner_found), 1);
        chk("wrap_seen", int'(wraps > 0), 1);

        // Random positions, enables and occasional FUPs
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0)
                step(800, 525, 1'($urandom));
            else
                step($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom));
        end

        // Asynchronous reset mid-line
        step(700, 10, 1'b1);
        chk_en = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_hsync", int'(hs), 1);
        chk("async_vsync", int'(vs), 1);
        chk("async_video", int'(vid), 0);
        chk("async_pixel", int'(pix), 0);
        chk("async_x", int'(bx), 100);
        chk("async_y", int'(by), 100);
        chk("async_bounces", int'(bc), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        step(800, 525, 1'b1);
        chk("rearm_x", int'(bx), 100);
        step(800, 525, 1'b1);
        chk("rearm_move_x", int'(bx), 102);
        step(1, 1, 1'b1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ball_renderer.md
Name: ball_renderer

Overview:
- Consumes the 1-based raster position (HPos 1..H_MAX, VPos 1..V_MAX) from the sync counter.
- Produces registered VGA sync, a video-active flag and a 1-bit ball pixel.
- Keeps a square ball's position and direction and updates them once per frame.
- Bounces the ball off the visible-area edges and counts the bounces.

Parameters:
- H_VISIBLE, 640, last visible column (columns 1..640)
- V_VISIBLE, 480, last visible line (lines 1..480)
- H_SYNC_START, 657, first HPos with HSync asserted
- H_SYNC_END, 752, last HPos with HSync asserted
- V_SYNC_START, 491, first VPos with VSync asserted
- V_SYNC_END, 492, last VPos with VSync asserted
- H_MAX, 800, last HPos of a line
- V_MAX, 525, last VPos of a frame
- BALL_SIZE, 8, ball edge length in pixels
- SPEED, 2, pixels moved per frame per axis (1..BALL_SIZE)
- X_INIT, 100, ball left column after reset
- Y_INIT, 100, ball top line after reset

Ports:
- i_Clk  input  1  pixel clock
- i_Rst_n  input  1  asynchronous active-low reset
- i_HPos  input  10  current column, 1-based
- i_VPos  input  10  current line, 1-based
- i_Enable  input  1  motion enable, sampled only at the frame-update point
- o_HSync  output  1  horizontal sync, active low, registered
- o_VSync  output  1  vertical sync, active low, registered
- o_Video  output  1  high when the position is inside the visible area, registered
- o_Pixel  output  1  high when the position is inside the ball and visible, registered
- o_BallX  output  10  ball left column
- o_BallY  output  10  ball top line
- o_Bounces  output  8  bounce count, wraps 255->0

Behaviour:
- One clock domain, i_Clk. Reset is asynchronous and active-low on i_Rst_n.
- Reset values:
  - o_HSync = 1, o_VSync = 1, o_Video = 0, o_Pixel = 0
  - o_BallX = X_INIT, o_BallY = Y_INIT
  - direction = right/down
  - o_Bounces = 0
  - state = WAIT_FRAME
- Raster outputs have 1-cycle latency. The outputs in cycle n+1 reflect i_HPos/i_VPos in cycle n:
  - o_HSync = 0 iff H_SYNC_START <= HPos <= H_SYNC_END.
  - o_VSync = 0 iff V_SYNC_START <= VPos <= V_SYNC_END.
  - o_Video = HPos <= H_VISIBLE && VPos <= V_VISIBLE.
  - o_Pixel = o_Video term && BallX <= HPos <= BallX+BALL_SIZE-1 && BallY <= VPos <= BallY+BALL_SIZE-1.
  - o_Pixel uses the ball registers current in cycle n.
- Ball limits: XMAX = H_VISIBLE-BALL_SIZE+1 (633), YMAX = V_VISIBLE-BALL_SIZE+1 (473), minimum 1 on both axes.
- Frame-update point (FUP): the cycle in which HPos == H_MAX && VPos == V_MAX.
- State machine:
  - WAIT_FRAME: no motion. Moves to RUN at the first FUP after reset. That FUP does not move the ball, so a partial first frame never moves it.
  - RUN: at each FUP with i_Enable = 1, update X then Y independently.
  - RUN, i_Enable = 0 at FUP: position and direction are held. No other state.
- X update (Y is identical, using YMAX and down/up):
  - Moving right: if X+SPEED >= XMAX, then X <= XMAX, direction <= left, bounce event. Otherwise X <= X+SPEED.
  - Moving left: if X <= SPEED+1, then X <= 1, direction <= right, bounce event. Otherwise X <= X-SPEED.
  - Compare in 11 bits so that no 10-bit wrap occurs.
- o_Bounces:
  - Adds 1 per axis bouncing at that FUP, so a corner hit adds 2 in one cycle.
  - Wraps modulo 256.
- Ball registers change only at an FUP. This makes a frame's image consistent, because the FUP is outside the visible area.
- Out-of-range inputs (HPos = 0 or HPos > H_MAX): treated by the comparisons above without special casing. No FUP occurs.
- Reset mid-frame: all outputs return to reset values immediately. The block re-enters WAIT_FRAME.

Test Plan:
- Reset held, then released at HPos=1, VPos=1 -> o_HSync=1, o_VSync=1, o_Pixel=0, BallX=BallY=100. After the first FUP: still 100,100. After the second FUP: 102,102.
- Sweep one full frame -> o_HSync low exactly for HPos 657..752 on every line, seen one cycle later. o_VSync low for all cycles with VPos 491..492. o_Video high for 640×480 cycles.
- Ball at (100,100) -> o_Pixel high for exactly 64 cycles per frame, at HPos 100..107 on VPos 100..107. Low at HPos 108.
- Force moving right at X=632 via run-up frames, with SPEED=2 -> next FUP gives X=633, direction left, o_Bounces +1. Following FUP gives X=631.
- Corner case, with X=2 moving left and Y=2 moving up -> after one FUP: (1,1), direction right/down, o_Bounces +2. Also preload o_Bounces to 255 and trigger one bounce -> wraps to 0.
- i_Enable=0 across two FUPs -> position unchanged. Assert reset mid-line -> outputs go to reset values without waiting for a clock edge.
